// File: rtl/cla_serial_add_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : cla_serial_add_sequencer
// Purpose  : Adds or subtracts two 4*NIBBLES-bit operands one nibble per clock
//            through a single shared 4-bit carry-lookahead slice, LSB first.
//            Reports carry-out and signed overflow with a one-cycle done pulse.
// Revision : 1.0 - initial release
// ============================================================================
module cla_serial_add_sequencer #(
  parameter int NIBBLES = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic                   sub,
  input  logic [4*NIBBLES-1:0]   a,
  input  logic [4*NIBBLES-1:0]   b,
  output logic                   ready,
  output logic                   busy,
  output logic                   done,
  output logic [4*NIBBLES-1:0]   result,
  output logic                   cout,
  output logic                   overflow
);

  localparam int WIDTH = 4 * NIBBLES;
  localparam int IDXW  = (NIBBLES < 2) ? 1 : $clog2(NIBBLES + 1);
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NIBBLES - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic [WIDTH-1:0]  a_r;
  logic [WIDTH-1:0]  b_r;
  logic              carry;
  logic [IDXW-1:0]   idx;
  logic              last;
  logic [3:0]        a_nib;
  logic [3:0]        b_nib;
  logic [3:0]        p;
  logic [3:0]        g;
  logic [4:0]        c;
  logic [3:0]        sum;

  assign last = (idx == LAST_IDX);

  // State register; reset aborts any operation in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic; handshake outputs are decoded from state only.
  always_comb begin
    state_nxt = state;
    ready     = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: begin
        ready = 1'b1;
        if (start) state_nxt = RUN;
      end
      RUN: begin
        busy = 1'b1;
        if (last) state_nxt = DONE;
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Select the operand nibbles addressed by idx with constant part-selects.
  always_comb begin
    a_nib = 4'h0;
    b_nib = 4'h0;
    for (int i = 0; i < NIBBLES; i++) begin
      if (idx == IDXW'(i)) begin
        a_nib = a_r[4*i +: 4];
        b_nib = b_r[4*i +: 4];
      end
    end
  end

  // Shared 4-bit slice: propagate/generate lookahead, no wide adder.
  assign p    = a_nib ^ b_nib;
  assign g    = a_nib & b_nib;
  assign c[0] = carry;
  assign c[1] = g[0] | (p[0] & c[0]);
  assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c[0]);
  assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
              | (p[2] & p[1] & p[0] & c[0]);
  assign c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
              | (p[3] & p[2] & p[1] & g[0]) | (p[3] & p[2] & p[1] & p[0] & c[0]);
  assign sum  = p ^ c[3:0];

  // Operand capture, per-nibble result write-back and final flag capture.
  // On the last nibble c[3] is the carry into the MSB, so overflow is
  // c[3]^c[4]; both flags become visible together with done.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_r      <= '0;
      b_r      <= '0;
      carry    <= 1'b0;
      idx      <= '0;
      result   <= '0;
      cout     <= 1'b0;
      overflow <= 1'b0;
    end else if (state == IDLE && start) begin
      a_r    <= a;
      b_r    <= sub ? ~b : b;
      carry  <= sub;
      idx    <= '0;
      result <= '0;
    end else if (state == RUN) begin
      for (int i = 0; i < NIBBLES; i++) begin
        if (idx == IDXW'(i)) result[4*i +: 4] <= sum;
      end
      carry <= c[4];
      idx   <= idx + IDXW'(1);
      if (last) begin
        cout     <= c[4];
        overflow <= c[3] ^ c[4];
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_cla_serial_add_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_cla_serial_add_sequencer
// Purpose  : Directed self-checking bench for cla_serial_add_sequencer
//            (NIBBLES=4) with hand-computed expected values.
// Revision : 1.0 - initial release
// ============================================================================
module tb_cla_serial_add_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic        sub;
  logic [15:0] a;
  logic [15:0] b;
  logic        ready;
  logic        busy;
  logic        done;
  logic [15:0] result;
  logic        cout;
  logic        overflow;

  int checks   = 0;
  int failures = 0;

  cla_serial_add_sequencer #(.NIBBLES(4)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .sub      (sub),
    .a        (a),
    .b        (b),
    .ready    (ready),
    .busy     (busy),
    .done     (done),
    .result   (result),
    .cout     (cout),
    .overflow (overflow)
  );

  // 10 ns clock, rising edge active
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Issue one operation from IDLE (called #1 after an edge) and check it.
  task automatic do_op(input string tag, input logic [15:0] ta, input logic [15:0] tb_v,
                       input logic ts, input logic [15:0] er, input logic ec, input logic eo);
    int lat;
    a = ta; b = tb_v; sub = ts; start = 1'b1;
    @(posedge clk); #1;                 // E0: accepted
    start = 1'b0;
    chk({tag, "_clr"}, 32'(result), 32'h0);
    chk({tag, "_busy"}, 32'(busy), 32'h1);
    lat = 0;
    for (int k = 1; k <= 12; k++) begin
      @(posedge clk); #1;
      if (done) begin lat = k; break; end
    end
    chk({tag, "_lat"}, 32'(lat), 32'd4);
    chk({tag, "_res"}, 32'(result), 32'(er));
    chk({tag, "_cout"}, 32'(cout), 32'(ec));
    chk({tag, "_ovf"}, 32'(overflow), 32'(eo));
    @(posedge clk); #1;
    chk({tag, "_pulse"}, 32'(done), 32'h0);
    chk({tag, "_rdy"}, 32'(ready), 32'h1);
    chk({tag, "_hold"}, 32'(result), 32'(er));
  endtask

  initial begin
    int busy_cnt;
    int done_cnt;
    logic exp_done;
    logic [15:0] exp_res;

    rst_n = 1'b0; start = 1'b0; sub = 1'b0; a = '0; b = '0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ready", 32'(ready), 32'h1);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_done", 32'(done), 32'h0);
    chk("rst_result", 32'(result), 32'h0);
    chk("rst_cout", 32'(cout), 32'h0);
    chk("rst_ovf", 32'(overflow), 32'h0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Directed arithmetic
    do_op("add1", 16'h1234, 16'h0FCD, 1'b0, 16'h2201, 1'b0, 1'b0);
    do_op("ripple", 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0);
    do_op("addovf", 16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1);
    do_op("sub1", 16'h0005, 16'h0007, 1'b1, 16'hFFFE, 1'b0, 1'b0);
    do_op("subovf", 16'h8000, 16'h0001, 1'b1, 16'h7FFF, 1'b1, 1'b1);

    // start pulsed with new operands throughout RUN and DONE is ignored
    a = 16'h1111; b = 16'h2222; sub = 1'b0; start = 1'b1;
    @(posedge clk); #1;                 // E0
    busy_cnt = busy ? 1 : 0;
    done_cnt = 0;
    for (int k = 1; k <= 6; k++) begin
      if (k <= 5) begin
        start = 1'b1;
        a = 16'h0F00 + 16'(k);
        b = 16'hA000 + 16'(k * 3);
        sub = k[0];
      end else begin
        start = 1'b0;
      end
      @(posedge clk); #1;               // E_k
      if (busy) busy_cnt++;
      if (done) begin
        done_cnt++;
        chk("ign_res", 32'(result), 32'h3333);
      end
    end
    start = 1'b0;
    chk("ign_busycnt", 32'(busy_cnt), 32'd4);
    chk("ign_donecnt", 32'(done_cnt), 32'd1);
    chk("ign_idle", 32'(ready), 32'h1);

    // start held high: each accepted op uses the operands present at its
    // accept edge. IDLE + 4 RUN + DONE gives a done every 6 edges.
    a = 16'h0123; b = 16'h0456; sub = 1'b0; start = 1'b1;
    exp_res = 16'h0579;
    done_cnt = 0;
    for (int n = 0; n <= 17; n++) begin
      @(posedge clk); #1;               // E_n, op accepted at E0/E6/E12
      exp_done = (n == 4) || (n == 10) || (n == 16);
      chk($sformatf("hold_done_%0d", n), 32'(done), 32'(exp_done));
      if (done) begin
        done_cnt++;
        chk($sformatf("hold_res_%0d", n), 32'(result), 32'(exp_res));
        if (n == 4)  begin a = 16'h1000; b = 16'h0001; exp_res = 16'h1001; end
        if (n == 10) begin a = 16'hFFF0; b = 16'h0020; exp_res = 16'h0010; end
      end
    end
    start = 1'b0;
    chk("hold_cout", 32'(cout), 32'h1);
    chk("hold_count", 32'(done_cnt), 32'd3);
    @(posedge clk); #1;                 // back in IDLE

    // Asynchronous reset during the third RUN cycle
    a = 16'h1234; b = 16'h0FCD; sub = 1'b0; start = 1'b1;
    @(posedge clk); #1;                 // E0
    start = 1'b0;
    @(posedge clk); #1;                 // E1
    @(posedge clk); #1;                 // E2: third RUN cycle in progress
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_ready", 32'(ready), 32'h1);
    chk("arst_busy", 32'(busy), 32'h0);
    chk("arst_done", 32'(done), 32'h0);
    chk("arst_result", 32'(result), 32'h0);
    chk("arst_cout", 32'(cout), 32'h0);
    chk("arst_ovf", 32'(overflow), 32'h0);
    done_cnt = 0;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      if (done) done_cnt++;
    end
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      if (done) done_cnt++;
    end
    chk("arst_nodone", 32'(done_cnt), 32'd0);
    do_op("postrst", 16'h0F0F, 16'h00F1, 1'b0, 16'h1000, 1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
